tdm_link_rx: RTL and testbench

Receive-side endpoint of the timer-partitioned link. The transmit side alternates a public (L) epoch and a secret (H) epoch on a shared bus, switching on a public countdown timer. This block regenerates the same epoch schedule from its own L timer and steers each accepted bus word into a per-level receive FIFO. The H side can never influence L-visible state, timing or backpressure.

---
 rtl/tdm_link_if.sv | 28 ++
 rtl/tdm_link_rx.sv | 123 ++++++++++++
 tb/tb_tdm_link_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdm_link_if.sv
// Bus bundle for the timer-partitioned link receiver: transmit beats in,
// epoch/timer status and the two per-level receive FIFO heads out.
interface tdm_link_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             epoch;
    logic [15:0]      timer;
    logic             l_valid;
    logic [WIDTH-1:0] l_data;
    logic             l_ready;
    logic [7:0]       l_drop;
    logic             h_valid;
    logic [WIDTH-1:0] h_data;
    logic             h_ready;
    logic [7:0]       h_drop;

    modport master (
        output in_valid, in_data, l_ready, h_ready,
        input  epoch, timer, l_valid, l_data, l_drop, h_valid, h_data, h_drop
    );

    modport slave (
        input  in_valid, in_data, l_ready, h_ready,
        output epoch, timer, l_valid, l_data, l_drop, h_valid, h_data, h_drop
    );
endinterface

// File: rtl/tdm_link_rx.sv
// Receive endpoint of the timer-partitioned link: regenerates the L/H epoch
// schedule from a public countdown and steers accepted words into per-level FIFOs.
module tdm_link_rx #(
    parameter int WIDTH = 16,
    parameter int EPOCH = 10,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    tdm_link_if.slave  bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = AW + 1;
    localparam logic [15:0] RELOAD = 16'(EPOCH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {EP_L = 1'b0, EP_H = 1'b1} epoch_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    epoch_e      epoch_q, epoch_d;
    logic [15:0] timer_q, timer_d;
    logic        guard;

    logic [WIDTH-1:0] l_mem_q [DEPTH];
    logic [AW-1:0]    l_wr_q, l_wr_d, l_rd_q, l_rd_d;
    logic [CW-1:0]    l_cnt_q, l_cnt_d;
    logic [7:0]       l_drop_q, l_drop_d;
    logic             l_req, l_pop, l_push;

    logic [WIDTH-1:0] h_mem_q [DEPTH];
    logic [AW-1:0]    h_wr_q, h_wr_d, h_rd_q, h_rd_d;
    logic [CW-1:0]    h_cnt_q, h_cnt_d;
    logic [7:0]       h_drop_q, h_drop_d;
    logic             h_req, h_pop, h_push;

    // Schedule depends only on the timer, so traffic can never shift it.
    always_comb begin
        guard   = (timer_q == 16'd0);
        epoch_d = epoch_q;
        timer_d = timer_q - 16'd1;
        if (guard) begin
            epoch_d = (epoch_q == EP_L) ? EP_H : EP_L;
            timer_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q <= EP_L;
            timer_q <= RELOAD;
        end else begin
            epoch_q <= epoch_d;
            timer_q <= timer_d;
        end
    end

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        l_req    = bus.in_valid && !guard && (epoch_q == EP_L);
        l_pop    = (l_cnt_q != '0) && bus.l_ready;
        l_push   = l_req && ((l_cnt_q != FULL) || l_pop);
        l_wr_d   = l_push ? l_wr_q + AW'(1) : l_wr_q;
        l_rd_d   = l_pop  ? l_rd_q + AW'(1) : l_rd_q;
        l_cnt_d  = l_cnt_q + CW'(l_push) - CW'(l_pop);
        l_drop_d = (l_req && !l_push) ? sat_inc(l_drop_q) : l_drop_q;
    end

    always_comb begin
        h_req    = bus.in_valid && !guard && (epoch_q == EP_H);
        h_pop    = (h_cnt_q != '0) && bus.h_ready;
        h_push   = h_req && ((h_cnt_q != FULL) || h_pop);
        h_wr_d   = h_push ? h_wr_q + AW'(1) : h_wr_q;
        h_rd_d   = h_pop  ? h_rd_q + AW'(1) : h_rd_q;
        h_cnt_d  = h_cnt_q + CW'(h_push) - CW'(h_pop);
        h_drop_d = (h_req && !h_push) ? sat_inc(h_drop_q) : h_drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_wr_q   <= '0;
            l_rd_q   <= '0;
            l_cnt_q  <= '0;
            l_drop_q <= '0;
        end else begin
            l_wr_q   <= l_wr_d;
            l_rd_q   <= l_rd_d;
            l_cnt_q  <= l_cnt_d;
            l_drop_q <= l_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_wr_q   <= '0;
            h_rd_q   <= '0;
            h_cnt_q  <= '0;
            h_drop_q <= '0;
        end else begin
            h_wr_q   <= h_wr_d;
            h_rd_q   <= h_rd_d;
            h_cnt_q  <= h_cnt_d;
            h_drop_q <= h_drop_d;
        end
    end

    // Storage is not reset; the heads are masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (l_push && !reset) l_mem_q[l_wr_q] <= bus.in_data;
        if (h_push && !reset) h_mem_q[h_wr_q] <= bus.in_data;
    end

    assign bus.epoch   = epoch_q;
    assign bus.timer   = timer_q;
    assign bus.l_valid = (l_cnt_q != '0);
    assign bus.l_data  = (l_cnt_q != '0) ? l_mem_q[l_rd_q] : '0;
    assign bus.l_drop  = l_drop_q;
    assign bus.h_valid = (h_cnt_q != '0);
    assign bus.h_data  = (h_cnt_q != '0) ? h_mem_q[h_rd_q] : '0;
    assign bus.h_drop  = h_drop_q;
endmodule

// File: tb/tb_tdm_link_rx.sv
// Randomized bench for tdm_link_rx against a queue-based model whose epoch
// schedule is computed arithmetically from the cycle count since reset.
module tb_tdm_link_rx;
    localparam int WIDTH = 16;
    localparam int EPOCH = 10;
    localparam int DEPTH = 4;
    localparam int P     = EPOCH + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdm_link_if #(.WIDTH(WIDTH)) bus ();

    tdm_link_rx #(.WIDTH(WIDTH), .EPOCH(EPOCH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int               mcyc;
    logic [WIDTH-1:0] lq[$];
    logic [WIDTH-1:0] hq[$];
    int               ldrop, hdrop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, obs, exp, mcyc);
        end
    endtask

    function automatic int m_timer();
        return EPOCH - (mcyc % P);
    endfunction

    function automatic int m_epoch();
        return (mcyc / P) % 2;
    endfunction

    task automatic check_all();
        chk("epoch",   32'(bus.epoch),   32'(m_epoch()));
        chk("timer",   32'(bus.timer),   32'(m_timer()));
        chk("l_valid", 32'(bus.l_valid), 32'(lq.size() != 0));
        chk("l_data",  32'(bus.l_data),  (lq.size() != 0) ? 32'(lq[0]) : 32'd0);
        chk("l_drop",  32'(bus.l_drop),  32'(ldrop));
        chk("h_valid", 32'(bus.h_valid), 32'(hq.size() != 0));
        chk("h_data",  32'(bus.h_data),  (hq.size() != 0) ? 32'(hq[0]) : 32'd0);
        chk("h_drop",  32'(bus.h_drop),  32'(hdrop));
    endtask

    task automatic model_clear();
        mcyc = 0;
        lq.delete();
        hq.delete();
        ldrop = 0;
        hdrop = 0;
    endtask

    task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit lr, input bit hr);
        bit guard;
        int ep;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.l_ready  = lr;
        bus.h_ready  = hr;
        guard = (m_timer() == 0);
        ep    = m_epoch();
        if (lr && lq.size() != 0) void'(lq.pop_front());
        if (hr && hq.size() != 0) void'(hq.pop_front());
        if (iv && !guard) begin
            if (ep == 0) begin
                if (lq.size() < DEPTH) lq.push_back(d);
                else if (ldrop < 255) ldrop++;
            end else begin
                if (hq.size() < DEPTH) hq.push_back(d);
                else if (hdrop < 255) hdrop++;
            end
        end
        @(posedge clk);
        #1;
        mcyc++;
        check_all();
    endtask

    task automatic do_reset(input bit iv);
        reset        = 1'b1;
        bus.in_valid = iv;
        bus.in_data  = 16'($urandom);
        bus.l_ready  = 1'($urandom);
        bus.h_ready  = 1'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_all();
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.l_ready  = 1'b0;
        bus.h_ready  = 1'b0;
        model_clear();

        do_reset(1'b0);
        chk("rst_epoch", 32'(bus.epoch), 32'd0);
        chk("rst_timer", 32'(bus.timer), 32'(EPOCH));

        // Idle schedule: toggles after cycles 10 and 21.
        for (int i = 0; i < 22; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("sched_epoch22", 32'(bus.epoch), 32'd0);

        // Words 1..10 into L with no consumer, word 11 lands on the guard.
        do_reset(1'b0);
        for (int i = 1; i <= 11; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_l_drop", 32'(bus.l_drop), 32'd6);
        chk("fill_l_data", 32'(bus.l_data), 32'd1);

        // One H word, then pop it; L side must be untouched.
        cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
        chk("h_one_valid", 32'(bus.h_valid), 32'd1);
        chk("h_one_data",  32'(bus.h_data),  32'hA5A5);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("h_pop_valid", 32'(bus.h_valid), 32'd0);
        chk("h_l_drop",    32'(bus.l_drop),  32'd6);
        chk("h_l_data",    32'(bus.l_data),  32'd1);
        while (mcyc % (2 * P) != 0) cycle(1'b0, '0, 1'b0, 1'b0);

        // Full L FIFO with push+pop every cycle across pointer wrap.
        for (int i = 0; i < EPOCH; i++) cycle(1'b1, 16'(16'h200 + i), 1'b1, 1'b0);
        chk("pp_l_drop",  32'(bus.l_drop),  32'd6);
        chk("pp_l_valid", 32'(bus.l_valid), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // H flood: drop count saturates; schedule is checked every cycle.
        do_reset(1'b0);
        for (int n = 0; n < 300;) begin
            bit hacc;
            hacc = (m_epoch() == 1) && (m_timer() != 0);
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
            if (hacc) n++;
        end
        chk("flood_h_drop", 32'(bus.h_drop), 32'd255);
        chk("flood_l_drop", 32'(bus.l_drop), 32'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom));
            else cycle($urandom_range(0, 3) != 0, 16'($urandom),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        // Reset mid-H with both FIFOs non-empty and both drop counts non-zero.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'h300 + i), 1'b0, 1'b0);
        while (m_epoch() == 0 || m_timer() == 0) cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'h400 + i), 1'b0, 1'b0);
        chk("pre_rst_l_drop", 32'(bus.l_drop),  32'd2);
        chk("pre_rst_h_drop", 32'(bus.h_drop),  32'd2);
        chk("pre_rst_h_val",  32'(bus.h_valid), 32'd1);
        do_reset(1'b1);
        chk("mid_rst_epoch",  32'(bus.epoch),   32'd0);
        chk("mid_rst_timer",  32'(bus.timer),   32'(EPOCH));
        chk("mid_rst_lvalid", 32'(bus.l_valid), 32'd0);
        chk("mid_rst_hvalid", 32'(bus.h_valid), 32'd0);
        chk("mid_rst_ldrop",  32'(bus.l_drop),  32'd0);
        chk("mid_rst_hdrop",  32'(bus.h_drop),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
